// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit for the 8-bit, 4-register CPU: owns PC/IR, sequences
// fetch/decode/exec/mem/writeback. Define RETIRE_CNT_EN to add the retire_cnt output.
module cpu_ctrl #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned IW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ready,
  input  logic [IW-1:0]   imem_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [7:0]      dmem_addr,
  input  logic            dmem_ready,
  input  logic [7:0]      alu_s,
  input  logic            zeroout,
  output logic [1:0]      Rs,
  output logic [1:0]      Rt,
  output logic [1:0]      Rd,
  output logic [7:0]      imm,
  output logic [2:0]      alucs,
  output logic            selscrB,
  output logic            regdes,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            flagwrite,
`ifdef RETIRE_CNT_EN
  output logic            halted,
  output logic [15:0]     retire_cnt
`else
  output logic            halted
`endif
);

  localparam logic [3:0] OpAddi = 4'h5;
  localparam logic [3:0] OpLd   = 4'h6;
  localparam logic [3:0] OpSt   = 4'h7;
  localparam logic [3:0] OpBeqz = 4'h8;
  localparam logic [3:0] OpJmp  = 4'h9;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [7:0]      daddr_q, daddr_d;
  logic [3:0]      op;
  logic            is_rtype;

  assign op       = ir_q[15:12];
  assign is_rtype = (op <= 4'h4);

  assign imem_addr = pc_q;
  assign dmem_addr = daddr_q;
  assign Rs        = ir_q[11:10];
  assign Rt        = ir_q[9:8];
  assign Rd        = ir_q[7:6];
  assign imm       = ir_q[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= '0;
      ir_q    <= '0;
      daddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      daddr_q <= daddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    daddr_d = daddr_q;
    case (state_q)
      StFetch: begin
        if (imem_ready) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        state_d = StFetch;
        case (op)
          OpLd, OpSt: begin
            daddr_d = alu_s;
            state_d = StMem;
          end
          // Taken branch overrides the increment already applied in fetch.
          OpBeqz: if (zeroout) pc_d = PC_W'(imm);
          OpJmp:  pc_d = PC_W'(imm);
          OpHalt: state_d = StHalt;
          default: ;
        endcase
      end
      StMem: begin
        if (dmem_ready) state_d = (op == OpLd) ? StWb : StFetch;
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alucs     = 3'b000;
    selscrB   = 1'b0;
    regdes    = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    flagwrite = 1'b0;
    halted    = 1'b0;
    case (state_q)
      // Reset state is FETCH, so gate the request to drop it while reset is held.
      StFetch: imem_req = rst_n;
      StExec: begin
        if (is_rtype) begin
          alucs     = op[2:0];
          regdes    = 1'b1;
          regwrite  = 1'b1;
          flagwrite = 1'b1;
        end else if (op == OpAddi) begin
          selscrB   = 1'b1;
          regwrite  = 1'b1;
          flagwrite = 1'b1;
        end else if (op == OpLd || op == OpSt) begin
          selscrB   = 1'b1;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OpSt);
      end
      StWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

`ifdef RETIRE_CNT_EN
  logic [15:0] retire_cnt_q, retire_cnt_d;
  logic        retire;

  always_comb begin
    retire = ((state_q == StExec) && (op != OpLd) && (op != OpSt)) ||
             ((state_q == StMem) && dmem_ready && (op == OpSt)) ||
             (state_q == StWb);
    retire_cnt_d = retire ? retire_cnt_q + 16'd1 : retire_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: the driver pushes expected output snapshots per
// instruction; a negedge monitor pops and compares on every handshake/enable event.
module tb_cpu_ctrl;

  logic        clk, rst_n;
  logic [7:0]  imem_addr;
  logic        imem_req, imem_ready;
  logic [15:0] imem_data;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [7:0]  dmem_addr, alu_s;
  logic        zeroout;
  logic [1:0]  Rs, Rt, Rd;
  logic [7:0]  imm;
  logic [2:0]  alucs;
  logic        selscrB, regdes, memtoreg, regwrite, flagwrite, halted;
`ifdef RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  cpu_ctrl #(.PC_W(8), .IW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ready(imem_ready),
    .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_ready(dmem_ready), .alu_s(alu_s), .zeroout(zeroout),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .imm(imm), .alucs(alucs), .selscrB(selscrB),
    .regdes(regdes), .memtoreg(memtoreg), .regwrite(regwrite), .flagwrite(flagwrite),
`ifdef RETIRE_CNT_EN
    .halted(halted), .retire_cnt(retire_cnt)
`else
    .halted(halted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gap;
    logic [7:0] pc;
    logic       ireq;
    logic       dreq;
    logic       dwe;
    logic [7:0] daddr;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
    logic [7:0] imm;
    logic [2:0] alucs;
    logic       sel;
    logic       regdes;
    logic       m2r;
    logic       rw;
    logic       fw;
    logic       halted;
  } snap_t;

  typedef struct {
    string name;
    snap_t s;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state tracked from the stimulus itself.
  logic [7:0]  m_pc, m_daddr;
  logic [15:0] m_ir;
  int          prev_lat, prev_mw, m_ret;
  bit          first;

  // Monitor: gap counts cycles between fetch handshakes (latency + wait states).
  int   cyc;
  logic halted_prev;
  always @(negedge clk) begin
    snap_t a;
    exp_t  e;
    logic  ev;
    if (!rst_n) begin
      cyc = 0;
      halted_prev = 1'b0;
    end else begin
      cyc++;
      a = '0;
      a.pc = imem_addr; a.ireq = imem_req; a.dreq = dmem_req; a.dwe = dmem_we;
      a.daddr = dmem_addr; a.rs = Rs; a.rt = Rt; a.rd = Rd; a.imm = imm;
      a.alucs = alucs; a.sel = selscrB; a.regdes = regdes; a.m2r = memtoreg;
      a.rw = regwrite; a.fw = flagwrite; a.halted = halted;
      ev = 1'b0;
      if (imem_req && imem_ready) begin
        a.gap = 8'(cyc);
        cyc = 0;
        ev = 1'b1;
      end
      if (regwrite || flagwrite || dmem_req || (halted && !halted_prev)) ev = 1'b1;
      halted_prev = halted;
      if (ev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event got %h required none", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e.s) begin
            n_fail++;
            $display("FAIL %s got %h required %h", e.name, a, e.s);
          end
        end
      end
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got %h required %h", n, act, req);
    end
  endtask

  function automatic snap_t base();
    snap_t s;
    s = '0;
    s.pc = m_pc; s.daddr = m_daddr;
    s.rs = m_ir[11:10]; s.rt = m_ir[9:8]; s.rd = m_ir[7:6]; s.imm = m_ir[7:0];
    return s;
  endfunction

  task automatic push(string n, snap_t s);
    exp_t e;
    e.name = n;
    e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_pc = '0; m_ir = '0; m_daddr = '0; first = 1'b1; m_ret = 0;
    prev_lat = 0; prev_mw = 0;
  endtask

  // Waits up to 50 cycles for sig; a timeout is a failed comparison.
  task automatic wait_req(string n, bit is_dmem, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (is_dmem ? dmem_req : imem_req) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout got 0 required 1", n);
    end
  endtask

  task automatic issue(logic [15:0] ir, int fw, int mw, logic [7:0] alu, logic z);
    snap_t      s;
    logic [3:0] op;
    int         lat;
    bit         ok;
    op = ir[15:12];
    s = base();
    s.ireq = 1'b1;
    s.gap  = first ? 8'(1 + fw) : 8'(prev_lat + prev_mw + fw);
    push("fetch", s);
    first = 1'b0;
    m_ir  = ir;
    m_pc  = m_pc + 8'd1;
    lat   = 3;
    m_ret++;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
        s = base(); s.alucs = op[2:0]; s.regdes = 1'b1; s.rw = 1'b1; s.fw = 1'b1;
        push("exec_alu", s);
      end
      4'h5: begin
        s = base(); s.sel = 1'b1; s.rw = 1'b1; s.fw = 1'b1;
        push("exec_addi", s);
      end
      4'h6, 4'h7: begin
        m_daddr = alu;
        for (int i = 0; i <= mw; i++) begin
          s = base(); s.dreq = 1'b1; s.dwe = (op == 4'h7);
          push((op == 4'h7) ? "mem_st" : "mem_ld", s);
        end
        lat = (op == 4'h6) ? 5 : 4;
        if (op == 4'h6) begin
          s = base(); s.m2r = 1'b1; s.rw = 1'b1;
          push("wb", s);
        end
      end
      4'h8: if (z) m_pc = ir[7:0];
      4'h9: m_pc = ir[7:0];
      4'hF: begin
        s = base(); s.halted = 1'b1;
        push("halt", s);
      end
      default: ;
    endcase
    prev_lat = lat;
    prev_mw  = (op == 4'h6 || op == 4'h7) ? mw : 0;

    wait_req("imem_req", 1'b0, ok);
    if (!ok) return;
    repeat (fw) begin @(posedge clk); #1; end
    imem_ready = 1'b1; imem_data = ir; alu_s = alu; zeroout = z;
    @(posedge clk); #1;
    imem_ready = 1'b0; imem_data = '0;
    if (op == 4'h6 || op == 4'h7) begin
      wait_req("dmem_req", 1'b1, ok);
      if (!ok) return;
      repeat (mw) begin @(posedge clk); #1; end
      dmem_ready = 1'b1;
      @(posedge clk); #1;
      dmem_ready = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0; imem_ready = 1'b0; imem_data = '0; dmem_ready = 1'b0;
    alu_s = '0; zeroout = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("req_in_reset", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_addr", 32'(imem_addr), 32'd0);
    chk("reset_enables", 32'({regwrite, flagwrite, dmem_req, halted, selscrB, memtoreg}), 32'd0);

    issue(16'h5105, 0, 0, 8'h05, 1'b0);   // ADDI R1,R0,5
    issue(16'h06C0, 1, 0, 8'h00, 1'b0);   // ADD R3,R1,R2
    issue(16'h1E40, 0, 0, 8'h00, 1'b0);   // SUB
    issue(16'h2000, 2, 0, 8'h00, 1'b0);   // AND
    issue(16'h3500, 0, 0, 8'h00, 1'b0);   // OR
    issue(16'h4AC0, 0, 0, 8'h00, 1'b0);   // ADC
    issue(16'h6603, 0, 2, 8'h08, 1'b0);   // LD R2,[R1+3], two wait states
    issue(16'h7D10, 1, 1, 8'h44, 1'b0);   // ST
    issue(16'h8020, 0, 0, 8'h00, 1'b1);   // BEQZ taken -> 0x20
    issue(16'h8020, 0, 0, 8'h00, 1'b0);   // BEQZ not taken -> 0x21
    issue(16'h90FF, 0, 0, 8'h00, 1'b0);   // JMP 0xFF
    issue(16'hA000, 0, 0, 8'h00, 1'b0);   // NOP at 0xFF, PC wraps to 0
    issue(16'h5BFF, 0, 0, 8'h00, 1'b0);   // ADDI at 0x00

    // Reset while a fetch is pending.
    wait_req("imem_req_pre_reset", 1'b0, ok);
    @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("pending_req", 32'(imem_req), 32'd1);
    chk("pending_addr", 32'(imem_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("req_drop_in_reset", 32'(imem_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    chk("reset2_addr", 32'(imem_addr), 32'd0);
    chk("reset2_fields", 32'({Rs, Rt, Rd, imm, dmem_addr}), 32'd0);
    chk("reset2_enables", 32'({regwrite, flagwrite, dmem_req, halted, regdes}), 32'd0);

    issue(16'h5105, 0, 0, 8'h05, 1'b0);
    issue(16'h6603, 0, 0, 8'h11, 1'b0);   // zero-wait LD
    issue(16'h7D10, 0, 0, 8'h22, 1'b0);   // zero-wait ST
    issue(16'h4AC0, 1, 0, 8'h00, 1'b0);
    issue(16'hF000, 0, 0, 8'h00, 1'b0);   // HALT

    repeat (6) @(posedge clk);
    #1;
    chk("halted_hold", 32'(halted), 32'd1);
    chk("halted_no_req", 32'({imem_req, dmem_req}), 32'd0);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
`ifdef RETIRE_CNT_EN
    chk("retire_cnt", 32'(retire_cnt), 32'(m_ret));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
